// File: rtl/bcm_scan_sequencer.sv
// BCM scan sequencer for a 64x32 HUB75 panel.
// Overlaps each row/plane load with display of the previously latched plane.
`timescale 1ns/1ps
module bcm_scan_sequencer #(
  parameter int PLANES      = 6,
  parameter int ROW_BITS    = 4,
  parameter int BASE_TICKS  = 16,
  parameter int BLANK_TICKS = 4,
  parameter int TICK_WIDTH  = 16
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                enable,
  input  logic [7:0]          brightness,
  input  logic                load_done,
  output logic                load_request,
  output logic [ROW_BITS-1:0] row_address,
  output logic [PLANES-1:0]   brightness_mask,
  output logic [ROW_BITS-1:0] row_address_active,
  output logic                row_latch,
  output logic                output_enable,
  output logic                frame_start
);

  localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int BW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
  localparam int FW = TICK_WIDTH + PLANES + 9;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    BLANK,
    LATCH
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]         plane;
  logic [ROW_BITS-1:0]   row;
  logic [TICK_WIDTH-1:0] slot_cnt;
  logic [TICK_WIDTH-1:0] on_cnt;
  logic [BW-1:0]         blank_cnt;
  logic                  load_seen;
  logic                  display_done;
  logic                  last_plane;
  logic [FW-1:0]         slot_full;
  logic [FW-1:0]         on_full;

  assign display_done = (slot_cnt == '0);
  assign last_plane   = (plane == PW'(PLANES - 1));
  assign row_address  = row;
  assign brightness_mask = PLANES'(1) << plane;
  assign output_enable = (on_cnt != '0) &&
                         (state != BLANK) &&
                         (state != LATCH);

  // On-time is the slot scaled by (brightness+1)/256.
  always_comb begin
    slot_full = FW'(BASE_TICKS) << plane;
    on_full   = (slot_full * FW'(9'(brightness) + 9'd1)) >> 8;
  end

  always_ff @(posedge clk_in) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load_request = 1'b0;
    row_latch    = 1'b0;
    frame_start  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) state_nxt = REQ;
      end
      REQ: begin
        load_request = 1'b1;
        frame_start  = (row == '0) && (plane == '0);
        state_nxt    = WAIT;
      end
      WAIT: begin
        if ((load_seen || load_done) && display_done)
          state_nxt = BLANK;
      end
      BLANK: begin
        if (blank_cnt == '0) state_nxt = LATCH;
      end
      LATCH: begin
        row_latch = 1'b1;
        state_nxt = enable ? REQ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      plane              <= '0;
      row                <= '0;
      slot_cnt           <= '0;
      on_cnt             <= '0;
      blank_cnt          <= '0;
      load_seen          <= 1'b0;
      row_address_active <= '0;
    end else begin
      if (state == LATCH) begin
        slot_cnt           <= TICK_WIDTH'(slot_full);
        on_cnt             <= TICK_WIDTH'(on_full);
        row_address_active <= row;
        if (last_plane) begin
          plane <= '0;
          row   <= row + 1'b1;
        end else begin
          plane <= plane + 1'b1;
        end
      end else begin
        if (slot_cnt != '0) slot_cnt <= slot_cnt - 1'b1;
        if (on_cnt != '0)   on_cnt   <= on_cnt - 1'b1;
      end
      if (state == IDLE && enable) begin
        plane <= '0;
        row   <= '0;
      end
      if (state == REQ)
        load_seen <= 1'b0;
      else if (state == WAIT && load_done)
        load_seen <= 1'b1;
      if (state == WAIT)
        blank_cnt <= BW'(BLANK_TICKS - 1);
      else if (state == BLANK)
        blank_cnt <= blank_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_bcm_scan_sequencer.sv
// Scoreboard bench for bcm_scan_sequencer.
// Loader model answers requests; monitor logs requests and latches.
`timescale 1ns/1ps
module tb_bcm_scan_sequencer;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] brightness = 8'd255;
  logic       load_done = 1'b0;
  logic       load_request;
  logic [3:0] row_address;
  logic [5:0] brightness_mask;
  logic [3:0] row_address_active;
  logic       row_latch;
  logic       output_enable;
  logic       frame_start;

  bcm_scan_sequencer dut (
    .clk_in             (clk_in),
    .reset              (reset),
    .enable             (enable),
    .brightness         (brightness),
    .load_done          (load_done),
    .load_request       (load_request),
    .row_address        (row_address),
    .brightness_mask    (brightness_mask),
    .row_address_active (row_address_active),
    .row_latch          (row_latch),
    .output_enable      (output_enable),
    .frame_start        (frame_start)
  );

  typedef struct packed {
    logic [3:0] row;
    logic [5:0] mask;
    logic       fs;
    int         cyc;
  } req_t;

  typedef struct packed {
    logic [3:0] row;
    logic [5:0] mask;
    int         oe;
    logic [4:0] hist;
    logic [3:0] act;
    int         cyc;
  } lat_t;

  req_t req_q[$];
  lat_t lat_q[$];
  int   dly_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   oe_run = 0;
  int   gen = 0;
  bit   ld_busy = 1'b0;
  int   errors = 0;
  int   checks = 0;

  initial forever #5 clk_in = ~clk_in;
  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  // Shifter model: one load_done per request after a queued delay.
  // A negative delay also fires a stray pulse in the REQ cycle.
  initial begin : loader
    int d;
    int g;
    forever begin
      @(negedge clk_in);
      if (load_request === 1'b1 && !reset) begin
        ld_busy = 1'b1;
        g = gen;
        if (dly_q.size() > 0) d = dly_q.pop_front();
        else d = 3;
        if (d < 0) begin
          load_done = 1'b1;
          @(negedge clk_in);
          load_done = 1'b0;
          d = -d - 1;
        end
        repeat (d) @(negedge clk_in);
        if (g == gen) begin
          load_done = 1'b1;
          done_q.push_back(cyc);
          @(negedge clk_in);
          load_done = 1'b0;
        end
        ld_busy = 1'b0;
      end
    end
  end

  initial begin : monitor
    lat_t       lr;
    req_t       rq;
    logic [4:0] hist;
    bit         pend;
    hist = '0;
    pend = 1'b0;
    lr = '0;
    forever begin
      @(negedge clk_in);
      if (reset) begin
        oe_run = 0;
        hist = '0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          lr.act = row_address_active;
          lat_q.push_back(lr);
          pend = 1'b0;
        end
        if (load_request) begin
          rq.row = row_address;
          rq.mask = brightness_mask;
          rq.fs = frame_start;
          rq.cyc = cyc;
          req_q.push_back(rq);
        end
        if (row_latch) begin
          lr.row = row_address;
          lr.mask = brightness_mask;
          lr.oe = oe_run;
          lr.hist = {hist[3:0], output_enable};
          lr.cyc = cyc;
          pend = 1'b1;
          oe_run = 0;
        end else if (output_enable) begin
          oe_run++;
        end
        hist = {hist[3:0], output_enable};
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int on_exp(input int p, input int b);
    return ((16 << p) * (b + 1)) >> 8;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_in);
      #1;
    end
  endtask

  task automatic start_run(input logic [7:0] b);
    reset = 1'b1;
    enable = 1'b0;
    brightness = b;
    gen++;
    for (int i = 0; i < 2000 && ld_busy; i++) tick(1);
    dly_q.delete();
    tick(2);
    reset = 1'b0;
    tick(1);
    req_q.delete();
    lat_q.delete();
    done_q.delete();
  endtask

  task automatic wait_lat(input int n, input int lim, output bit ok);
    int i = 0;
    while (lat_q.size() < n && i < lim) begin
      tick(1);
      i++;
    end
    ok = (lat_q.size() >= n);
  endtask

  task automatic wait_req(input int n, input int lim, output bit ok);
    int i = 0;
    while (req_q.size() < n && i < lim) begin
      tick(1);
      i++;
    end
    ok = (req_q.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    checks++;
    if ({load_request, row_latch, frame_start} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 000",
               {load_request, row_latch, frame_start});
    end
    checks++;
    if (output_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_oe: got %b want 0", output_enable);
    end
    checks++;
    if (row_address !== 4'd0 || row_address_active !== 4'd0) begin
      errors++;
      $display("FAIL reset_rows: got %0d/%0d want 0/0",
               row_address, row_address_active);
    end
    checks++;
    if (brightness_mask !== 6'b000001) begin
      errors++;
      $display("FAIL reset_mask: got %b want 000001", brightness_mask);
    end
    tick(5);
    checks++;
    if (load_request !== 1'b0 || output_enable !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got req=%b oe=%b want 0 0",
               load_request, output_enable);
    end
  endtask

  task automatic test_first_request();
    int c0;
    bit ok;
    start_run(8'd255);
    c0 = cyc;
    enable = 1'b1;
    wait_req(1, 10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL first_req_timeout: got 0 requests want 1");
    end else begin
      checks++;
      if (req_q[0].cyc !== c0 + 1) begin
        errors++;
        $display("FAIL first_req_cycle: got %0d want %0d", req_q[0].cyc, c0 + 1);
      end
      checks++;
      if ({req_q[0].row, req_q[0].mask, req_q[0].fs} !== {4'd0, 6'b000001, 1'b1}) begin
        errors++;
        $display("FAIL first_req_pos: got row=%0d mask=%b fs=%b want 0 000001 1",
                 req_q[0].row, req_q[0].mask, req_q[0].fs);
      end
    end
    wait_lat(2, 200, ok);
    checks++;
    if (!ok || done_q.size() < 1) begin
      errors++;
      $display("FAIL first_latch_timeout: got %0d latches want 2", lat_q.size());
    end else begin
      checks++;
      if (lat_q[0].cyc - done_q[0] !== 5) begin
        errors++;
        $display("FAIL first_latch_delay: got %0d want 5", lat_q[0].cyc - done_q[0]);
      end
      checks++;
      if (lat_q[1].oe !== 16) begin
        errors++;
        $display("FAIL plane0_oe: got %0d want 16", lat_q[1].oe);
      end
    end
  endtask

  task automatic test_full_frame();
    bit ok;
    start_run(8'd255);
    enable = 1'b1;
    wait_lat(97, 20000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_timeout: got %0d latches want 97", lat_q.size());
    end
    for (int i = 0; i < 97 && i < req_q.size(); i++) begin
      logic [3:0] er;
      logic [5:0] em;
      logic       ef;
      er = 4'((i / 6) % 16);
      em = 6'(1 << (i % 6));
      ef = (i % 96 == 0);
      checks++;
      if (req_q[i].row !== er || req_q[i].mask !== em || req_q[i].fs !== ef) begin
        errors++;
        $display("FAIL frame_req[%0d]: got row=%0d mask=%b fs=%b want row=%0d mask=%b fs=%b",
                 i, req_q[i].row, req_q[i].mask, req_q[i].fs, er, em, ef);
      end
    end
    for (int i = 0; i < 97 && i < lat_q.size(); i++) begin
      logic [3:0] er;
      logic [5:0] em;
      int         eoe;
      er = 4'((i / 6) % 16);
      em = 6'(1 << (i % 6));
      eoe = (i == 0) ? 0 : on_exp((i - 1) % 6, 255);
      checks++;
      if (lat_q[i].row !== er || lat_q[i].mask !== em || lat_q[i].oe !== eoe ||
          lat_q[i].hist !== 5'b0 || lat_q[i].act !== er) begin
        errors++;
        $display("FAIL frame_latch[%0d]: got row=%0d mask=%b oe=%0d blank_oe=%b act=%0d want row=%0d mask=%b oe=%0d blank_oe=00000 act=%0d",
                 i, lat_q[i].row, lat_q[i].mask, lat_q[i].oe, lat_q[i].hist,
                 lat_q[i].act, er, em, eoe, er);
      end
    end
    if (lat_q.size() >= 97) begin
      checks++;
      if (lat_q[96].cyc - lat_q[0].cyc !== 16704) begin
        errors++;
        $display("FAIL frame_period: got %0d want 16704", lat_q[96].cyc - lat_q[0].cyc);
      end
      checks++;
      if (lat_q[6].oe !== 512) begin
        errors++;
        $display("FAIL plane5_oe: got %0d want 512", lat_q[6].oe);
      end
    end
  endtask

  task automatic test_dimming();
    bit ok;
    start_run(8'd0);
    enable = 1'b1;
    wait_lat(7, 3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL dim0_timeout: got %0d latches want 7", lat_q.size());
    end else begin
      for (int i = 1; i < 7; i++) begin
        checks++;
        if (lat_q[i].oe !== on_exp(i - 1, 0)) begin
          errors++;
          $display("FAIL dim0_plane%0d: got %0d want %0d", i - 1, lat_q[i].oe, on_exp(i - 1, 0));
        end
      end
      checks++;
      if (lat_q[1].oe !== 0 || lat_q[6].oe !== 2) begin
        errors++;
        $display("FAIL dim0_ends: got p0=%0d p5=%0d want 0 2", lat_q[1].oe, lat_q[6].oe);
      end
      checks++;
      if (lat_q[6].cyc - lat_q[5].cyc !== 518) begin
        errors++;
        $display("FAIL dim0_slot5: got %0d want 518", lat_q[6].cyc - lat_q[5].cyc);
      end
    end
    start_run(8'd127);
    enable = 1'b1;
    wait_lat(7, 3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL dim127_timeout: got %0d latches want 7", lat_q.size());
    end else begin
      for (int i = 1; i < 7; i++) begin
        checks++;
        if (lat_q[i].oe !== on_exp(i - 1, 127)) begin
          errors++;
          $display("FAIL dim127_plane%0d: got %0d want %0d", i - 1, lat_q[i].oe, on_exp(i - 1, 127));
        end
      end
      checks++;
      if (lat_q[4].oe !== 64) begin
        errors++;
        $display("FAIL dim127_plane3: got %0d want 64", lat_q[4].oe);
      end
    end
  endtask

  task automatic test_slow_loader();
    bit ok;
    start_run(8'd255);
    dly_q = '{3, 3, 3, 3, 3, 3, 700, -40};
    enable = 1'b1;
    wait_lat(9, 4000, ok);
    checks++;
    if (!ok || done_q.size() < 7) begin
      errors++;
      $display("FAIL slow_timeout: got %0d latches want 9", lat_q.size());
    end else begin
      checks++;
      if (lat_q[6].oe !== 512) begin
        errors++;
        $display("FAIL slow_oe: got %0d want 512", lat_q[6].oe);
      end
      checks++;
      if (lat_q[6].cyc - lat_q[5].cyc !== 706) begin
        errors++;
        $display("FAIL slow_interval: got %0d want 706", lat_q[6].cyc - lat_q[5].cyc);
      end
      checks++;
      if (lat_q[6].cyc - done_q[6] !== 5) begin
        errors++;
        $display("FAIL slow_blank_after_done: got %0d want 5", lat_q[6].cyc - done_q[6]);
      end
      checks++;
      if (lat_q[6].row !== 4'd1 || lat_q[6].mask !== 6'b000001 || lat_q[6].hist !== 5'b0) begin
        errors++;
        $display("FAIL slow_latch_pos: got row=%0d mask=%b blank_oe=%b want 1 000001 00000",
                 lat_q[6].row, lat_q[6].mask, lat_q[6].hist);
      end
      checks++;
      if (lat_q[7].cyc - lat_q[6].cyc !== 46) begin
        errors++;
        $display("FAIL spurious_req_done: got %0d want 46", lat_q[7].cyc - lat_q[6].cyc);
      end
      checks++;
      if (lat_q[7].oe !== 16) begin
        errors++;
        $display("FAIL spurious_oe: got %0d want 16", lat_q[7].oe);
      end
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int c0;
    start_run(8'd255);
    dly_q = '{3, 3, 20};
    enable = 1'b1;
    wait_req(3, 500, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drop_timeout: got %0d requests want 3", req_q.size());
    end
    tick(2);
    enable = 1'b0;
    tick(600);
    checks++;
    if (lat_q.size() !== 3 || req_q.size() !== 3) begin
      errors++;
      $display("FAIL drop_counts: got latches=%0d reqs=%0d want 3 3", lat_q.size(), req_q.size());
    end
    checks++;
    if (oe_run !== 64) begin
      errors++;
      $display("FAIL drop_plane_complete: got %0d want 64", oe_run);
    end
    checks++;
    if (output_enable !== 1'b0 || load_request !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: got oe=%b req=%b want 0 0", output_enable, load_request);
    end
    c0 = cyc;
    enable = 1'b1;
    wait_req(4, 10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reenable_timeout: got %0d requests want 4", req_q.size());
    end else begin
      checks++;
      if ({req_q[3].row, req_q[3].mask, req_q[3].fs} !== {4'd0, 6'b000001, 1'b1} ||
          req_q[3].cyc !== c0 + 1) begin
        errors++;
        $display("FAIL reenable_pos: got row=%0d mask=%b fs=%b cyc=%0d want 0 000001 1 %0d",
                 req_q[3].row, req_q[3].mask, req_q[3].fs, req_q[3].cyc, c0 + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_run(8'd255);
    enable = 1'b1;
    wait_lat(5, 2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midrst_timeout: got %0d latches want 5", lat_q.size());
    end
    tick(100);
    reset = 1'b1;
    gen++;
    tick(1);
    checks++;
    if ({output_enable, row_latch, load_request} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_strobes: got %b want 000", {output_enable, row_latch, load_request});
    end
    checks++;
    if (row_address !== 4'd0 || brightness_mask !== 6'b000001 || row_address_active !== 4'd0) begin
      errors++;
      $display("FAIL midrst_pos: got row=%0d mask=%b act=%0d want 0 000001 0",
               row_address, brightness_mask, row_address_active);
    end
    reset = 1'b0;
    req_q.delete();
    lat_q.delete();
    done_q.delete();
    wait_lat(1, 50, ok);
    checks++;
    if (!ok || req_q.size() < 1 || done_q.size() < 1) begin
      errors++;
      $display("FAIL midrst_resume_timeout: got %0d latches want 1", lat_q.size());
    end else begin
      checks++;
      if ({req_q[0].row, req_q[0].mask, req_q[0].fs} !== {4'd0, 6'b000001, 1'b1}) begin
        errors++;
        $display("FAIL midrst_resume_pos: got row=%0d mask=%b fs=%b want 0 000001 1",
                 req_q[0].row, req_q[0].mask, req_q[0].fs);
      end
      checks++;
      if (lat_q[0].oe !== 0 || lat_q[0].cyc - done_q[0] !== 5) begin
        errors++;
        $display("FAIL midrst_counters: got oe=%0d delay=%0d want 0 5",
                 lat_q[0].oe, lat_q[0].cyc - done_q[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_request();
    test_full_frame();
    test_dimming();
    test_slow_loader();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
